// File: rtl/lc3_pkg.sv
// Shared definitions for the LC-3 memory controller: device register map,
// controller FSM encoding and keyboard/display status bit positions.
package lc3_pkg;

   localparam logic [15:0] KBSR_ADDR = 16'hFE00;
   localparam logic [15:0] KBDR_ADDR = 16'hFE02;
   localparam logic [15:0] DSR_ADDR  = 16'hFE04;
   localparam logic [15:0] DDR_ADDR  = 16'hFE06;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   localparam int KBSR_RDY = 15;
   localparam int KBSR_IE  = 14;
   localparam int KBSR_OVR = 13;
   localparam int DSR_DRDY = 15;

   // True for the four memory-mapped device registers.
   function automatic logic is_dev_addr(input logic [15:0] a);
      return (a == KBSR_ADDR) || (a == KBDR_ADDR) ||
             (a == DSR_ADDR)  || (a == DDR_ADDR);
   endfunction

endpackage

// File: rtl/kbd_disp_regs.sv
// Keyboard/display device registers. An access strobe arrives on the same
// edge the controller accepts the request; read data is combinational so the
// controller can register it into MEM_OUT on that edge.
module kbd_disp_regs
   import lc3_pkg::*;
#(
   parameter int KB_OVR_EN = 1
) (
   input  logic        i_Clk,
   input  logic        i_Rst_n,
   input  logic        i_Acc,
   input  logic        i_We,
   input  logic [15:0] i_Addr,
   input  logic        i_Ie_Wbit,
   input  logic [7:0]  i_Ddr_Wdata,
   output logic [15:0] o_Rdata,
   input  logic        i_Kb_Valid,
   input  logic [7:0]  i_Kb_Data,
   output logic        o_Disp_Valid,
   output logic [7:0]  o_Disp_Data,
   input  logic        i_Disp_Ready
);

   localparam logic LP_OVR = (KB_OVR_EN != 0);

   logic       r_Rdy, r_Ie, r_Ovr;
   logic [7:0] r_Kbdr;
   logic       r_Disp_Valid;
   logic [7:0] r_Disp_Data;

   logic w_Rd_Kbsr, w_Rd_Kbdr, w_Wr_Kbsr, w_Wr_Ddr;

   assign w_Rd_Kbsr = i_Acc & ~i_We & (i_Addr == KBSR_ADDR);
   assign w_Rd_Kbdr = i_Acc & ~i_We & (i_Addr == KBDR_ADDR);
   assign w_Wr_Kbsr = i_Acc &  i_We & (i_Addr == KBSR_ADDR);
   assign w_Wr_Ddr  = i_Acc &  i_We & (i_Addr == DDR_ADDR);

   // Read mux: zero-extended register views, pre-update values.
   always_comb begin
      o_Rdata = '0;
      case (i_Addr)
         KBSR_ADDR: begin
            o_Rdata[KBSR_RDY] = r_Rdy;
            o_Rdata[KBSR_IE]  = r_Ie;
            o_Rdata[KBSR_OVR] = r_Ovr;
         end
         KBDR_ADDR: o_Rdata[7:0]     = r_Kbdr;
         DSR_ADDR:  o_Rdata[DSR_DRDY] = ~r_Disp_Valid;
         default:   o_Rdata = '0;
      endcase
   end

   // Keyboard state: a new character beats a same-cycle KBDR-read clear,
   // and an overrun beats a same-cycle KBSR-read clear.
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_Rdy  <= 1'b0;
         r_Ie   <= 1'b0;
         r_Ovr  <= 1'b0;
         r_Kbdr <= '0;
      end else begin
         if (i_Kb_Valid) begin
            r_Kbdr <= i_Kb_Data;
            r_Rdy  <= 1'b1;
         end else if (w_Rd_Kbdr) begin
            r_Rdy  <= 1'b0;
         end
         if (i_Kb_Valid && r_Rdy && LP_OVR)
            r_Ovr <= 1'b1;
         else if (w_Rd_Kbsr)
            r_Ovr <= 1'b0;
         if (w_Wr_Kbsr)
            r_Ie <= i_Ie_Wbit;
      end
   end

   // Display holding register: a write while a character is pending is dropped.
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_Disp_Valid <= 1'b0;
         r_Disp_Data  <= '0;
      end else if (w_Wr_Ddr && !r_Disp_Valid) begin
         r_Disp_Valid <= 1'b1;
         r_Disp_Data  <= i_Ddr_Wdata;
      end else if (r_Disp_Valid && i_Disp_Ready) begin
         r_Disp_Valid <= 1'b0;
      end
   end

   assign o_Disp_Valid = r_Disp_Valid;
   assign o_Disp_Data  = r_Disp_Data;

endmodule

// File: rtl/mem_ctrl.sv
// LC-3 memory access controller: accepts one MAR/MDR request per MIO_EN,
// runs a fixed-latency SRAM cycle or a single-cycle device access, and
// returns a one-cycle ready pulse with registered read data.
module mem_ctrl
   import lc3_pkg::*;
#(
   parameter int WAIT_CYCLES = 2,
   parameter int KB_OVR_EN   = 1
) (
   input  logic        i_Clk,
   input  logic        i_Rst_n,
   input  logic [15:0] MAR,
   input  logic [15:0] MDR,
   input  logic        MIO_EN,
   input  logic        R_W,
   output logic        o_R,
   output logic [15:0] MEM_OUT,
   output logic        o_Mem_En,
   output logic        o_Mem_We,
   output logic [15:0] o_Mem_Addr,
   output logic [15:0] o_Mem_Wdata,
   input  logic [15:0] i_Mem_Rdata,
   input  logic        i_Kb_Valid,
   input  logic [7:0]  i_Kb_Data,
   output logic        o_Disp_Valid,
   output logic [7:0]  o_Disp_Data,
   input  logic        i_Disp_Ready
);

   localparam logic [3:0] LP_LAST = 4'(WAIT_CYCLES - 1);

   state_t      r_State, w_Next;
   logic [3:0]  r_Cnt;
   logic [15:0] r_Addr, r_Wdata, r_Mem_Out;
   logic        r_We;

   logic        w_Accept, w_Dev, w_Last;
   logic [15:0] w_Dev_Rdata;

   assign w_Accept = (r_State == ST_IDLE) & MIO_EN;
   assign w_Dev    = is_dev_addr(MAR);
   assign w_Last   = (r_Cnt == LP_LAST);

   // State register.
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) r_State <= ST_IDLE;
      else          r_State <= w_Next;
   end

   // Next state and SRAM/ready strobes; strobes decode from state so reset
   // drops them immediately.
   always_comb begin
      w_Next   = r_State;
      o_R      = 1'b0;
      o_Mem_En = 1'b0;
      o_Mem_We = 1'b0;
      case (r_State)
         ST_IDLE: begin
            if (MIO_EN) w_Next = w_Dev ? ST_DONE : ST_ACCESS;
         end
         ST_ACCESS: begin
            o_Mem_En = 1'b1;
            o_Mem_We = r_We;
            if (w_Last) w_Next = ST_DONE;
         end
         ST_DONE: begin
            o_R    = 1'b1;
            w_Next = ST_IDLE;
         end
         default: w_Next = ST_IDLE;
      endcase
   end

   // Request latches and access-cycle counter.
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_Addr  <= '0;
         r_Wdata <= '0;
         r_We    <= 1'b0;
         r_Cnt   <= '0;
      end else if (w_Accept) begin
         r_Addr  <= MAR;
         r_Wdata <= MDR;
         r_We    <= R_W;
         r_Cnt   <= '0;
      end else if (r_State == ST_ACCESS) begin
         r_Cnt   <= r_Cnt + 4'd1;
      end
   end

   // Read data register: only completed reads update it.
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n)
         r_Mem_Out <= '0;
      else if (w_Accept && w_Dev && !R_W)
         r_Mem_Out <= w_Dev_Rdata;
      else if ((r_State == ST_ACCESS) && w_Last && !r_We)
         r_Mem_Out <= i_Mem_Rdata;
   end

   assign MEM_OUT     = r_Mem_Out;
   assign o_Mem_Addr  = r_Addr;
   assign o_Mem_Wdata = r_Wdata;

   kbd_disp_regs #(.KB_OVR_EN(KB_OVR_EN)) u_regs (
      .i_Clk        (i_Clk),
      .i_Rst_n      (i_Rst_n),
      .i_Acc        (w_Accept & w_Dev),
      .i_We         (R_W),
      .i_Addr       (MAR),
      .i_Ie_Wbit    (MDR[KBSR_IE]),
      .i_Ddr_Wdata  (MDR[7:0]),
      .o_Rdata      (w_Dev_Rdata),
      .i_Kb_Valid   (i_Kb_Valid),
      .i_Kb_Data    (i_Kb_Data),
      .o_Disp_Valid (o_Disp_Valid),
      .o_Disp_Data  (o_Disp_Data),
      .i_Disp_Ready (i_Disp_Ready)
   );

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: table of accesses with hand-computed results,
// plus sequences for the coincident keyboard strobe and mid-access reset.
module tb_mem_ctrl;

   logic        i_Clk = 1'b0;
   logic        i_Rst_n;
   logic [15:0] MAR, MDR;
   logic        MIO_EN, R_W;
   logic        o_R;
   logic [15:0] MEM_OUT;
   logic        o_Mem_En, o_Mem_We;
   logic [15:0] o_Mem_Addr, o_Mem_Wdata, i_Mem_Rdata;
   logic        i_Kb_Valid;
   logic [7:0]  i_Kb_Data;
   logic        o_Disp_Valid;
   logic [7:0]  o_Disp_Data;
   logic        i_Disp_Ready;

   int chk_cnt = 0;
   int pass_cnt = 0;

   mem_ctrl #(.WAIT_CYCLES(2), .KB_OVR_EN(1)) dut (
      .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .MAR(MAR), .MDR(MDR),
      .MIO_EN(MIO_EN), .R_W(R_W), .o_R(o_R), .MEM_OUT(MEM_OUT),
      .o_Mem_En(o_Mem_En), .o_Mem_We(o_Mem_We), .o_Mem_Addr(o_Mem_Addr),
      .o_Mem_Wdata(o_Mem_Wdata), .i_Mem_Rdata(i_Mem_Rdata),
      .i_Kb_Valid(i_Kb_Valid), .i_Kb_Data(i_Kb_Data),
      .o_Disp_Valid(o_Disp_Valid), .o_Disp_Data(o_Disp_Data),
      .i_Disp_Ready(i_Disp_Ready)
   );

   always #5 i_Clk = ~i_Clk;

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] sram;
      int          nkb;
      logic [7:0]  kc0;
      logic [7:0]  kc1;
      logic        dr;
      int          lat;
      logic [15:0] out;
      logic        dv;
      logic [7:0]  dd;
   } vec_t;

   vec_t vec [18];

   task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", n, act, exp);
   endtask

   task automatic kb_strobe(input logic [7:0] c);
      @(negedge i_Clk);
      i_Kb_Valid = 1'b1;
      i_Kb_Data  = c;
      @(negedge i_Clk);
      i_Kb_Valid = 1'b0;
   endtask

   // One request through to its ready pulse; checks latency, bus drive,
   // read data and that ready lasts one cycle.
   task automatic access(input string tag, input logic we, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic [15:0] sram,
                         input logic kb_same, input logic [7:0] kc,
                         input int exp_lat, input logic [15:0] exp_out);
      int lat = 0;
      int en_cnt = 0;
      int bad = 0;
      logic [15:0] out_at_r = '0;
      @(negedge i_Clk);
      MAR = addr; MDR = wdata; R_W = we; MIO_EN = 1'b1;
      i_Mem_Rdata = sram;
      if (kb_same) begin i_Kb_Valid = 1'b1; i_Kb_Data = kc; end
      for (int k = 1; k <= 20 && lat == 0; k++) begin
         @(negedge i_Clk);
         if (k == 1) i_Kb_Valid = 1'b0;
         if (o_Mem_En) begin
            en_cnt++;
            if (o_Mem_We !== we || o_Mem_Addr !== addr || (we && o_Mem_Wdata !== wdata))
               bad++;
         end
         if (o_R) begin
            lat = k;
            out_at_r = MEM_OUT;
            MIO_EN = 1'b0;
         end
      end
      MIO_EN = 1'b0;
      chk({tag, "_lat"}, 16'(lat), 16'(exp_lat));
      chk({tag, "_en"}, 16'(en_cnt), 16'(exp_lat - 1));
      chk({tag, "_bus"}, 16'(bad), 16'd0);
      chk({tag, "_out"}, out_at_r, exp_out);
      @(negedge i_Clk);
      chk({tag, "_rpulse"}, {15'd0, o_R}, 16'd0);
   endtask

   initial begin
      // we addr wdata sram nkb kc0 kc1 dr lat out dv dd
      vec[0]  = '{1'b0, 16'h3000, 16'h0000, 16'h1234, 0, 8'h00, 8'h00, 1'b0, 3, 16'h1234, 1'b0, 8'h00};
      vec[1]  = '{1'b1, 16'h4000, 16'h00FF, 16'hBEEF, 0, 8'h00, 8'h00, 1'b0, 3, 16'h1234, 1'b0, 8'h00};
      vec[2]  = '{1'b0, 16'hFE00, 16'h0000, 16'h0000, 1, 8'h41, 8'h00, 1'b0, 1, 16'h8000, 1'b0, 8'h00};
      vec[3]  = '{1'b0, 16'hFE02, 16'h0000, 16'h0000, 0, 8'h00, 8'h00, 1'b0, 1, 16'h0041, 1'b0, 8'h00};
      vec[4]  = '{1'b0, 16'hFE00, 16'h0000, 16'h0000, 0, 8'h00, 8'h00, 1'b0, 1, 16'h0000, 1'b0, 8'h00};
      vec[5]  = '{1'b0, 16'hFE00, 16'h0000, 16'h0000, 2, 8'h41, 8'h42, 1'b0, 1, 16'hA000, 1'b0, 8'h00};
      vec[6]  = '{1'b0, 16'hFE00, 16'h0000, 16'h0000, 0, 8'h00, 8'h00, 1'b0, 1, 16'h8000, 1'b0, 8'h00};
      vec[7]  = '{1'b0, 16'hFE02, 16'h0000, 16'h0000, 0, 8'h00, 8'h00, 1'b0, 1, 16'h0042, 1'b0, 8'h00};
      vec[8]  = '{1'b1, 16'hFE06, 16'h0058, 16'h0000, 0, 8'h00, 8'h00, 1'b0, 1, 16'h0042, 1'b1, 8'h58};
      vec[9]  = '{1'b0, 16'hFE04, 16'h0000, 16'h0000, 0, 8'h00, 8'h00, 1'b0, 1, 16'h0000, 1'b1, 8'h58};
      vec[10] = '{1'b1, 16'hFE06, 16'h0077, 16'h0000, 0, 8'h00, 8'h00, 1'b0, 1, 16'h0000, 1'b1, 8'h58};
      vec[11] = '{1'b0, 16'hFE04, 16'h0000, 16'h0000, 0, 8'h00, 8'h00, 1'b1, 1, 16'h8000, 1'b0, 8'h58};
      vec[12] = '{1'b0, 16'hFE06, 16'h0000, 16'h0000, 0, 8'h00, 8'h00, 1'b0, 1, 16'h0000, 1'b0, 8'h58};
      vec[13] = '{1'b1, 16'hFE00, 16'hFFFF, 16'h0000, 0, 8'h00, 8'h00, 1'b0, 1, 16'h0000, 1'b0, 8'h58};
      vec[14] = '{1'b0, 16'hFE00, 16'h0000, 16'h0000, 0, 8'h00, 8'h00, 1'b0, 1, 16'h4000, 1'b0, 8'h58};
      vec[15] = '{1'b1, 16'hFE02, 16'h1234, 16'h0000, 0, 8'h00, 8'h00, 1'b0, 1, 16'h4000, 1'b0, 8'h58};
      vec[16] = '{1'b0, 16'hFE02, 16'h0000, 16'h0000, 0, 8'h00, 8'h00, 1'b0, 1, 16'h0042, 1'b0, 8'h58};
      vec[17] = '{1'b1, 16'hFE00, 16'h0000, 16'h0000, 0, 8'h00, 8'h00, 1'b0, 1, 16'h0042, 1'b0, 8'h58};

      i_Rst_n = 1'b0; MAR = '0; MDR = '0; MIO_EN = 1'b0; R_W = 1'b0;
      i_Mem_Rdata = '0; i_Kb_Valid = 1'b0; i_Kb_Data = '0; i_Disp_Ready = 1'b0;
      repeat (2) @(negedge i_Clk);
      chk("rst_r", {15'd0, o_R}, 16'd0);
      chk("rst_en", {14'd0, o_Mem_En, o_Mem_We}, 16'd0);
      chk("rst_out", MEM_OUT, 16'h0000);
      chk("rst_addr", o_Mem_Addr, 16'h0000);
      chk("rst_wdata", o_Mem_Wdata, 16'h0000);
      chk("rst_disp", {7'd0, o_Disp_Valid, o_Disp_Data}, 16'h0000);
      i_Rst_n = 1'b1;

      for (int i = 0; i < 18; i++) begin
         if (vec[i].nkb >= 1) kb_strobe(vec[i].kc0);
         if (vec[i].nkb >= 2) kb_strobe(vec[i].kc1);
         if (vec[i].dr) begin
            @(negedge i_Clk); i_Disp_Ready = 1'b1;
            @(negedge i_Clk); i_Disp_Ready = 1'b0;
         end
         access($sformatf("v%0d", i), vec[i].we, vec[i].addr, vec[i].wdata,
                vec[i].sram, 1'b0, 8'h00, vec[i].lat, vec[i].out);
         chk($sformatf("v%0d_dv", i), {15'd0, o_Disp_Valid}, {15'd0, vec[i].dv});
         chk($sformatf("v%0d_dd", i), {8'd0, o_Disp_Data}, {8'd0, vec[i].dd});
      end

      // Character arrives on the same edge as a KBDR read: old char returned,
      // RDY stays set and the second character counts as an overrun.
      kb_strobe(8'h50);
      access("kbsame", 1'b0, 16'hFE02, 16'h0, 16'h0, 1'b1, 8'h51, 1, 16'h0050);
      access("kbsame_sr", 1'b0, 16'hFE00, 16'h0, 16'h0, 1'b0, 8'h00, 1, 16'hA000);
      access("kbsame_dr", 1'b0, 16'hFE02, 16'h0, 16'h0, 1'b0, 8'h00, 1, 16'h0051);

      // Reset in the middle of an SRAM access.
      @(negedge i_Clk);
      MAR = 16'h5000; R_W = 1'b0; MIO_EN = 1'b1; i_Mem_Rdata = 16'hCAFE;
      @(negedge i_Clk);
      chk("mid_en", {15'd0, o_Mem_En}, 16'd1);
      #2 i_Rst_n = 1'b0;
      #1;
      chk("mid_rst_en", {14'd0, o_Mem_En, o_Mem_We}, 16'd0);
      chk("mid_rst_r", {15'd0, o_R}, 16'd0);
      chk("mid_rst_out", MEM_OUT, 16'h0000);
      chk("mid_rst_addr", o_Mem_Addr, 16'h0000);
      MIO_EN = 1'b0;
      repeat (2) @(negedge i_Clk);
      i_Rst_n = 1'b1;
      begin
         int rc = 0;
         for (int k = 0; k < 5; k++) begin
            @(negedge i_Clk);
            if (o_R || o_Mem_En) rc++;
         end
         chk("mid_no_r", 16'(rc), 16'd0);
      end
      access("post_dsr", 1'b0, 16'hFE04, 16'h0, 16'h0, 1'b0, 8'h00, 1, 16'h8000);
      access("post_kbsr", 1'b0, 16'hFE00, 16'h0, 16'h0, 1'b0, 8'h00, 1, 16'h0000);
      access("post_kbdr", 1'b0, 16'hFE02, 16'h0, 16'h0, 1'b0, 8'h00, 1, 16'h0000);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
